matrix_slot_allocator: RTL and testbench
========================================

// Module: matrix_slot_allocator
// PURPOSE
//  Downstream storage manager for the generate/input modes. Grants a free matrix slot and its
//  BRAM base address on an alloc handshake, then records the matrix descriptor (m, n, addr) on commit.
//  Holds the descriptor table that the display and compute modes read back through a query port.
//  When the table is full, it evicts the oldest committed slot (FIFO order).
// PARAMETERS
//  NUM_SLOTS   8    number of descriptor slots (<=16, slot index is 4 bits)
//  SLOT_WORDS  256  BRAM words reserved per slot (fits MAX_DIM 16 x 16)
//  ADDR_WIDTH  `BRAM_ADDR_WIDTH  BRAM address width; must hold NUM_SLOTS*SLOT_WORDS-1
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  alloc_req     in   1   level request from a mode FSM; may stay high after the grant
//  alloc_cancel  in   1   abandons the pending grant (mode exit or timeout)
//  alloc_valid   out  1   1-cycle grant pulse
//  alloc_slot    out  4   granted slot; valid with alloc_valid and held until the next grant
//  alloc_addr    out  AW  granted base = alloc_slot*SLOT_WORDS; held with alloc_slot
//  commit_req    in   1   1-cycle pulse: write the descriptor
//  commit_slot   in   4   slot index being committed
//  commit_m      in   5   rows (1..16)
//  commit_n      in   5   columns (1..16)
//  commit_addr   in   AW  base address being committed
//  clear_all     in   1   1-cycle pulse: invalidate every slot
//  query_slot    in   4   slot index to read
//  query_valid   out  1   descriptor-valid flag of query_slot (registered, 1-cycle latency)
//  query_m       out  5   rows of query_slot (registered)
//  query_n       out  5   columns of query_slot (registered)
//  query_addr    out  AW  base address of query_slot (registered)
//  used_count    out  5   number of valid slots
//  error_code    out  4   `ERR_NONE / `ERR_COMMIT (bad commit); sticky until the next good commit or clear_all
// BEHAVIOUR
//  Reset: all outputs 0, every valid bit 0, evict_ptr 0, state IDLE, error_code `ERR_NONE.
//  FSM states:
//   IDLE: when alloc_req=1, pick the lowest slot with valid=0.
//    If every slot is valid, pick evict_ptr and clear that slot's valid bit in the same cycle.
//    Register alloc_slot and alloc_addr, assert alloc_valid the next cycle, go to GRANTED.
//    Grant latency is exactly 1 cycle from the first sampled alloc_req.
//   GRANTED: alloc_req is ignored here (the requester may hold it for 1 or more cycles after the grant).
//    commit_req with commit_slot==alloc_slot: write m, n, addr; set valid.
//    If this slot was the eviction victim, advance evict_ptr mod NUM_SLOTS.
//    Go to IDLE. A new grant needs alloc_req seen in IDLE, at the earliest 1 cycle after the commit.
//    alloc_cancel: return to IDLE with no table change; an evicted slot stays invalid.
//  Eviction order: evict_ptr advances only on an evicting commit.
//   Back-to-back batch generation into a full table therefore overwrites slots 0,1,2,... in order.
//  Bad commit: any of the following leaves the table unchanged, sets error_code=`ERR_COMMIT, keeps state:
//   commit_req in IDLE; commit_slot!=alloc_slot; m or n equal to 0 or >16; commit_addr!=alloc_addr.
//  Priority in the same cycle: clear_all > alloc_cancel > commit_req > alloc_req.
//   clear_all: clears all valid bits and evict_ptr, forces IDLE, drops any pending grant.
//  used_count: registered population count of the valid bits; updated 1 cycle after each change.
//  Query: reads are registered. If a commit hits query_slot, the new descriptor appears in the following cycle.
//  query_slot >= NUM_SLOTS returns query_valid=0 and zero fields.
//  Asynchronous reset mid-GRANTED: drops the grant; the requester's next alloc_req starts fresh.
// TESTING
//  1. Reset, then alloc_req held 3 cycles -> one alloc_valid pulse 1 cycle later, slot 0, addr 0.
//     Commit 2x3 -> query 0 gives valid, m=2, n=3; used_count=1.
//  2. 8 alloc/commit pairs, then a 9th alloc -> slot 0 (evict) with valid cleared.
//     10th pair -> slot 1; used_count stays 8.
//  3. After a grant of slot 2, commit_slot=3 -> error_code=`ERR_COMMIT, slot 3 still invalid.
//     Commit of slot 2 then succeeds and error_code returns to `ERR_NONE.
//  4. Grant, then alloc_cancel -> back to IDLE; the next alloc grants the same lowest free slot.
//  5. clear_all and commit_req in the same cycle -> all slots invalid, used_count=0, no write.
//  6. Commit with m=0 or n=17 -> rejected with `ERR_COMMIT; reset asserted in GRANTED -> all outputs 0.

Source files
------------

// File: rtl/matrix_slot_allocator.sv
// Matrix slot allocator: grants BRAM slots to generate/input modes, stores committed
// matrix descriptors, and evicts the oldest committed slot when the table is full.
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 11
`endif
`ifndef ERR_NONE
`define ERR_NONE 4'd0
`endif
`ifndef ERR_COMMIT
`define ERR_COMMIT 4'd1
`endif

module matrix_slot_allocator #(
    parameter int NUM_SLOTS  = 8,
    parameter int SLOT_WORDS = 256,
    parameter int ADDR_WIDTH = `BRAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req,
    input  logic                  alloc_cancel,
    output logic                  alloc_valid,
    output logic [3:0]            alloc_slot,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  commit_req,
    input  logic [3:0]            commit_slot,
    input  logic [4:0]            commit_m,
    input  logic [4:0]            commit_n,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    input  logic                  clear_all,
    input  logic [3:0]            query_slot,
    output logic                  query_valid,
    output logic [4:0]            query_m,
    output logic [4:0]            query_n,
    output logic [ADDR_WIDTH-1:0] query_addr,
    output logic [4:0]            used_count,
    output logic [3:0]            error_code
);

    localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [0:0] {IDLE, GRANTED} state_t;

    state_t                state, state_next;
    logic [NUM_SLOTS-1:0]  valid;
    logic [4:0]            m_tab    [NUM_SLOTS];
    logic [4:0]            n_tab    [NUM_SLOTS];
    logic [ADDR_WIDTH-1:0] addr_tab [NUM_SLOTS];
    logic [IW-1:0]         evict_ptr;
    logic                  victim;

    logic                  all_valid;
    logic [IW-1:0]         free_idx;
    logic [IW-1:0]         grant_idx;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic                  commit_ok;
    logic                  query_in_range;
    logic                  do_grant, do_commit, do_clear, bad_commit;

    // Lowest-index free slot; scanning downward lets the smallest index win.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = IW'(i);
            end
        end
    end

    assign all_valid      = &valid;
    assign grant_idx      = all_valid ? evict_ptr : free_idx;
    assign grant_addr     = ADDR_WIDTH'(grant_idx) * ADDR_WIDTH'(SLOT_WORDS);
    assign commit_ok      = (commit_slot == alloc_slot) && (commit_addr == alloc_addr) &&
                            (commit_m != 5'd0) && (commit_m <= 5'd16) &&
                            (commit_n != 5'd0) && (commit_n <= 5'd16);
    assign query_in_range = ({1'b0, query_slot} < 5'(NUM_SLOTS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Same-cycle priority: clear_all, then alloc_cancel, then commit_req, then alloc_req.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_commit  = 1'b0;
        do_clear   = 1'b0;
        bad_commit = 1'b0;
        if (clear_all) begin
            do_clear   = 1'b1;
            state_next = IDLE;
        end else if (state == GRANTED) begin
            if (alloc_cancel) begin
                state_next = IDLE;
            end else if (commit_req) begin
                if (commit_ok) begin
                    do_commit  = 1'b1;
                    state_next = IDLE;
                end else begin
                    bad_commit = 1'b1;
                end
            end
        end else if (!alloc_cancel) begin
            if (commit_req) begin
                bad_commit = 1'b1;
            end else if (alloc_req) begin
                do_grant   = 1'b1;
                state_next = GRANTED;
            end
        end
    end

    // Descriptor table, grant registers and eviction bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid       <= '0;
            evict_ptr   <= '0;
            victim      <= 1'b0;
            alloc_valid <= 1'b0;
            alloc_slot  <= '0;
            alloc_addr  <= '0;
            error_code  <= `ERR_NONE;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                m_tab[i]    <= '0;
                n_tab[i]    <= '0;
                addr_tab[i] <= '0;
            end
        end else begin
            alloc_valid <= do_grant;
            if (do_clear) begin
                valid      <= '0;
                evict_ptr  <= '0;
                victim     <= 1'b0;
                error_code <= `ERR_NONE;
            end
            if (do_grant) begin
                alloc_slot <= 4'(grant_idx);
                alloc_addr <= grant_addr;
                victim     <= all_valid;
                if (all_valid) begin
                    valid[evict_ptr] <= 1'b0;
                end
            end
            if (do_commit) begin
                m_tab[alloc_slot[IW-1:0]]    <= commit_m;
                n_tab[alloc_slot[IW-1:0]]    <= commit_n;
                addr_tab[alloc_slot[IW-1:0]] <= commit_addr;
                valid[alloc_slot[IW-1:0]]    <= 1'b1;
                error_code                   <= `ERR_NONE;
                victim                       <= 1'b0;
                if (victim) begin
                    evict_ptr <= (evict_ptr == IW'(NUM_SLOTS - 1)) ? '0 : evict_ptr + 1'b1;
                end
            end
            if (bad_commit) begin
                error_code <= `ERR_COMMIT;
            end
        end
    end

    // Registered read-back port and population count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            query_valid <= 1'b0;
            query_m     <= '0;
            query_n     <= '0;
            query_addr  <= '0;
            used_count  <= '0;
        end else begin
            used_count <= 5'($countones(valid));
            if (query_in_range) begin
                query_valid <= valid[query_slot[IW-1:0]];
                query_m     <= m_tab[query_slot[IW-1:0]];
                query_n     <= n_tab[query_slot[IW-1:0]];
                query_addr  <= addr_tab[query_slot[IW-1:0]];
            end else begin
                query_valid <= 1'b0;
                query_m     <= '0;
                query_n     <= '0;
                query_addr  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Self-checking bench for matrix_slot_allocator: grant and query expectations are queued
// when stimulus is driven and compared when the DUT produces them.
module tb_matrix_slot_allocator;

    localparam int AW = 11;
    localparam int SW = 256;
    localparam logic [3:0] ERR_NONE   = 4'd0;
    localparam logic [3:0] ERR_COMMIT = 4'd1;

    logic          clk;
    logic          rst_n;
    logic          alloc_req, alloc_cancel, alloc_valid;
    logic [3:0]    alloc_slot;
    logic [AW-1:0] alloc_addr;
    logic          commit_req;
    logic [3:0]    commit_slot;
    logic [4:0]    commit_m, commit_n;
    logic [AW-1:0] commit_addr;
    logic          clear_all;
    logic [3:0]    query_slot;
    logic          query_valid;
    logic [4:0]    query_m, query_n;
    logic [AW-1:0] query_addr;
    logic [4:0]    used_count;
    logic [3:0]    error_code;

    matrix_slot_allocator #(.NUM_SLOTS(8), .SLOT_WORDS(SW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_cancel(alloc_cancel), .alloc_valid(alloc_valid),
        .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
        .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
        .commit_n(commit_n), .commit_addr(commit_addr), .clear_all(clear_all),
        .query_slot(query_slot), .query_valid(query_valid), .query_m(query_m),
        .query_n(query_n), .query_addr(query_addr), .used_count(used_count),
        .error_code(error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]    slot;
        logic [AW-1:0] addr;
    } grant_t;

    typedef struct packed {
        logic          v;
        logic [4:0]    m;
        logic [4:0]    n;
        logic [AW-1:0] addr;
        logic          fields;
    } query_t;

    grant_t grant_q[$];
    query_t query_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every grant pulse must match the oldest outstanding expectation.
    grant_t g_mon;
    always @(negedge clk) begin
        if (alloc_valid) begin
            if (grant_q.size() == 0) begin
                checkOutput("unexpected_grant", 32'd1, 32'd0);
            end else begin
                g_mon = grant_q.pop_front();
                checkOutput("grant_slot", 32'(alloc_slot), 32'(g_mon.slot));
                checkOutput("grant_addr", 32'(alloc_addr), 32'(g_mon.addr));
            end
        end
    end

    task automatic applyStimulus(input logic req, input logic cancel, input logic cmt,
                                 input int cs, input int m, input int n, input int ca,
                                 input logic clr);
        alloc_req    = req;
        alloc_cancel = cancel;
        commit_req   = cmt;
        commit_slot  = 4'(cs);
        commit_m     = 5'(m);
        commit_n     = 5'(n);
        commit_addr  = AW'(ca);
        clear_all    = clr;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic allocExpect(input int slot, input int hold);
        grant_t g;
        g.slot = 4'(slot);
        g.addr = AW'(slot * SW);
        grant_q.push_back(g);
        repeat (hold) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        idleCycle();
        checkOutput("grant_seen", 32'(grant_q.size()), 32'd0);
        grant_q.delete();
    endtask

    task automatic commitDesc(input int slot, input int m, input int n, input int addr);
        applyStimulus(1'b0, 1'b0, 1'b1, slot, m, n, addr, 1'b0);
        idleCycle();
    endtask

    task automatic queryExpect(input int slot, input logic v, input int m, input int n,
                               input int addr, input logic fields);
        query_t e;
        e.v = v; e.m = 5'(m); e.n = 5'(n); e.addr = AW'(addr); e.fields = fields;
        query_q.push_back(e);
        query_slot = 4'(slot);
        @(negedge clk);
        e = query_q.pop_front();
        checkOutput("query_valid", 32'(query_valid), 32'(e.v));
        if (e.fields) begin
            checkOutput("query_m", 32'(query_m), 32'(e.m));
            checkOutput("query_n", 32'(query_n), 32'(e.n));
            checkOutput("query_addr", 32'(query_addr), 32'(e.addr));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        alloc_req    = 1'b0;
        alloc_cancel = 1'b0;
        commit_req   = 1'b0;
        commit_slot  = '0;
        commit_m     = '0;
        commit_n     = '0;
        commit_addr  = '0;
        clear_all    = 1'b0;
        query_slot   = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_alloc_valid", 32'(alloc_valid), 32'd0);
        checkOutput("rst_alloc_slot", 32'(alloc_slot), 32'd0);
        checkOutput("rst_alloc_addr", 32'(alloc_addr), 32'd0);
        checkOutput("rst_query_valid", 32'(query_valid), 32'd0);
        checkOutput("rst_used_count", 32'(used_count), 32'd0);
        checkOutput("rst_error_code", 32'(error_code), 32'(ERR_NONE));
        rst_n = 1'b1;
        idleCycle();

        $display("[TB] held request, single grant, first commit");
        allocExpect(0, 3);
        commitDesc(0, 2, 3, 0);
        queryExpect(0, 1'b1, 2, 3, 0, 1'b1);
        checkOutput("used_after_first", 32'(used_count), 32'd1);

        $display("[TB] fill table then evict in FIFO order");
        for (int i = 1; i < 8; i++) begin
            allocExpect(i, 1);
            commitDesc(i, i + 1, 16 - i, i * SW);
        end
        checkOutput("used_full", 32'(used_count), 32'd8);
        queryExpect(7, 1'b1, 8, 9, 7 * SW, 1'b1);
        queryExpect(9, 1'b0, 0, 0, 0, 1'b1);
        allocExpect(0, 1);
        queryExpect(0, 1'b0, 0, 0, 0, 1'b0);
        checkOutput("used_during_evict", 32'(used_count), 32'd7);
        commitDesc(0, 4, 4, 0);
        allocExpect(1, 1);
        commitDesc(1, 16, 16, SW);
        queryExpect(1, 1'b1, 16, 16, SW, 1'b1);
        checkOutput("used_after_evicts", 32'(used_count), 32'd8);

        $display("[TB] clear_all beats a simultaneous commit");
        allocExpect(2, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 2, 5, 5, 2 * SW, 1'b1);
        idleCycle();
        checkOutput("used_after_clear", 32'(used_count), 32'd0);
        checkOutput("err_after_clear", 32'(error_code), 32'(ERR_NONE));
        queryExpect(2, 1'b0, 0, 0, 0, 1'b0);
        queryExpect(0, 1'b0, 0, 0, 0, 1'b0);

        $display("[TB] commit to the wrong slot is rejected");
        allocExpect(0, 1);
        commitDesc(0, 1, 1, 0);
        allocExpect(1, 1);
        commitDesc(1, 1, 1, SW);
        allocExpect(2, 1);
        commitDesc(3, 5, 6, 3 * SW);
        checkOutput("err_wrong_slot", 32'(error_code), 32'(ERR_COMMIT));
        queryExpect(3, 1'b0, 0, 0, 0, 1'b0);
        commitDesc(2, 5, 6, 2 * SW);
        checkOutput("err_cleared_by_commit", 32'(error_code), 32'(ERR_NONE));
        queryExpect(2, 1'b1, 5, 6, 2 * SW, 1'b1);
        checkOutput("used_three", 32'(used_count), 32'd3);

        $display("[TB] cancel returns the same free slot");
        allocExpect(3, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        idleCycle();
        allocExpect(3, 2);
        commitDesc(3, 7, 2, 3 * SW);
        queryExpect(3, 1'b1, 7, 2, 3 * SW, 1'b1);

        $display("[TB] bad dimensions and address");
        allocExpect(4, 1);
        commitDesc(4, 0, 3, 4 * SW);
        checkOutput("err_m_zero", 32'(error_code), 32'(ERR_COMMIT));
        commitDesc(4, 3, 17, 4 * SW);
        checkOutput("err_n_17", 32'(error_code), 32'(ERR_COMMIT));
        commitDesc(4, 3, 4, 0);
        checkOutput("err_bad_addr", 32'(error_code), 32'(ERR_COMMIT));
        queryExpect(4, 1'b0, 0, 0, 0, 1'b0);
        commitDesc(4, 3, 4, 4 * SW);
        checkOutput("err_after_good", 32'(error_code), 32'(ERR_NONE));
        checkOutput("used_five", 32'(used_count), 32'd5);

        $display("[TB] reset while a grant is pending");
        allocExpect(5, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_alloc_slot", 32'(alloc_slot), 32'd0);
        checkOutput("midrst_alloc_addr", 32'(alloc_addr), 32'd0);
        checkOutput("midrst_used", 32'(used_count), 32'd0);
        checkOutput("midrst_query_m", 32'(query_m), 32'd0);
        checkOutput("midrst_query_addr", 32'(query_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycle();
        allocExpect(0, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        commitDesc(0, 2, 2, 0);
        checkOutput("err_commit_idle", 32'(error_code), 32'(ERR_COMMIT));
        queryExpect(0, 1'b0, 0, 0, 0, 1'b0);

        repeat (2) idleCycle();
        checkOutput("grant_q_drained", 32'(grant_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
